// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: opcodes, state encodings and datapath select encodings for the multicycle control FSM
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEM_ADDR = 4'd2;
    localparam logic [3:0] S_MEM_RD   = 4'd3;
    localparam logic [3:0] S_MEM_WB   = 4'd4;
    localparam logic [3:0] S_MEM_WR   = 4'd5;
    localparam logic [3:0] S_R_EXEC   = 4'd6;
    localparam logic [3:0] S_R_WB     = 4'd7;
    localparam logic [3:0] S_BRANCH   = 4'd8;
    localparam logic [3:0] S_JUMP     = 4'd9;
    localparam logic [3:0] S_JAL      = 4'd10;
    localparam logic [3:0] S_TRAP     = 4'd11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    localparam logic [1:0] RD_RT = 2'b00;
    localparam logic [1:0] RD_RD = 2'b01;
    localparam logic [1:0] RD_RA = 2'b10;

    localparam logic [1:0] M2R_ALUOUT = 2'b00;
    localparam logic [1:0] M2R_MDR    = 2'b01;
    localparam logic [1:0] M2R_PC     = 2'b10;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    // DECODE dispatch target for an opcode; anything unknown traps
    function automatic logic [3:0] decode_state(input logic [5:0] op);
        return (op == OP_RTYPE)              ? S_R_EXEC   :
               (op == OP_LW || op == OP_SW)  ? S_MEM_ADDR :
               (op == OP_BEQ)                ? S_BRANCH   :
               (op == OP_J)                  ? S_JUMP     :
               (op == OP_JAL)                ? S_JAL      : S_TRAP;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm_if.sv
// multicycle_ctrl_fsm_if: unified memory port request/ready handshake
interface multicycle_ctrl_fsm_if;

    logic mem_req;
    logic mem_we;
    logic mem_ready;

    modport master (output mem_req, output mem_we, input mem_ready);
    modport slave  (input mem_req, input mem_we, output mem_ready);

endinterface

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: counts stalled memory cycles and flags the last allowed one
module mem_wait_timer #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic expire
);

    logic [7:0] cnt;

    // Wait counter: restarts on every state change, advances while stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc)
            cnt <= cnt + 8'd1;
    end

    assign expire = (cnt == 8'(MAX_WAIT - 1));

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// multicycle_ctrl_fsm: main control FSM sequencing a multicycle MIPS datapath
module multicycle_ctrl_fsm
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned MAX_WAIT  = 15,
    parameter bit          TRAP_HALT = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  opcode,
    input  logic        zero,
    multicycle_ctrl_fsm_if.master mem,
    output logic        iord,
    output logic        ir_write,
    output logic        pc_en,
    output logic [1:0]  pc_src,
    output logic        reg_write,
    output logic [1:0]  reg_dst,
    output logic [1:0]  mem_to_reg,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic        instr_done,
    output logic        illegal,
    output logic        bus_err,
    output logic [3:0]  state_dbg
);

    logic [3:0] state;
    logic [3:0] next_state;
    logic [5:0] op_q;
    logic       illegal_q;
    logic       bus_err_q;
    logic       req;
    logic       we;
    logic       expire;

    mem_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (next_state != state),
        .inc    (req && !mem.mem_ready),
        .expire (expire)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_FETCH;
        else
            state <= next_state;
    end

    // Opcode copy for the lw/sw split and trap cause, latched on TRAP entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q      <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            if (state == S_DECODE)
                op_q <= opcode;
            if (next_state == S_TRAP && state != S_TRAP) begin
                illegal_q <= (state == S_DECODE);
                bus_err_q <= (state != S_DECODE);
            end else if (state == S_TRAP && next_state != S_TRAP) begin
                illegal_q <= 1'b0;
                bus_err_q <= 1'b0;
            end
        end
    end

    // Next-state: memory states wait for ready, a stall on the last allowed cycle traps
    always_comb begin
        next_state = S_FETCH;
        case (state)
            S_FETCH:    next_state = mem.mem_ready ? S_DECODE : (expire ? S_TRAP : S_FETCH);
            S_DECODE:   next_state = decode_state(opcode);
            S_MEM_ADDR: next_state = (op_q == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   next_state = mem.mem_ready ? S_MEM_WB : (expire ? S_TRAP : S_MEM_RD);
            S_MEM_WR:   next_state = mem.mem_ready ? S_FETCH : (expire ? S_TRAP : S_MEM_WR);
            S_R_EXEC:   next_state = S_R_WB;
            S_TRAP:     next_state = TRAP_HALT ? S_TRAP : S_FETCH;
            default:    next_state = S_FETCH;
        endcase
    end

    // Outputs: Moore per state, with ready/zero gating; all forced low while in reset
    always_comb begin
        req        = 1'b0;
        we         = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_en      = 1'b0;
        pc_src     = PC_ALU;
        reg_write  = 1'b0;
        reg_dst    = RD_RT;
        mem_to_reg = M2R_ALUOUT;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_REG;
        alu_op     = ALU_ADD;
        instr_done = 1'b0;
        illegal    = 1'b0;
        bus_err    = 1'b0;
        if (rst_n) begin
            case (state)
                S_FETCH: begin
                    req       = 1'b1;
                    alu_src_b = SRCB_FOUR;
                    ir_write  = mem.mem_ready;
                    pc_en     = mem.mem_ready;
                end
                S_DECODE: alu_src_b = SRCB_IMM_SH;
                S_MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_IMM;
                end
                S_MEM_RD: begin
                    req  = 1'b1;
                    iord = 1'b1;
                end
                S_MEM_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = M2R_MDR;
                    instr_done = 1'b1;
                end
                S_MEM_WR: begin
                    req        = 1'b1;
                    we         = 1'b1;
                    iord       = 1'b1;
                    instr_done = mem.mem_ready;
                end
                S_R_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_op    = ALU_FUNCT;
                end
                S_R_WB: begin
                    reg_write  = 1'b1;
                    reg_dst    = RD_RD;
                    instr_done = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a  = 1'b1;
                    alu_op     = ALU_SUB;
                    pc_src     = PC_ALUOUT;
                    pc_en      = zero;
                    instr_done = 1'b1;
                end
                S_JUMP: begin
                    pc_en      = 1'b1;
                    pc_src     = PC_JUMP;
                    instr_done = 1'b1;
                end
                S_JAL: begin
                    reg_write  = 1'b1;
                    reg_dst    = RD_RA;
                    mem_to_reg = M2R_PC;
                    pc_en      = 1'b1;
                    pc_src     = PC_JUMP;
                    instr_done = 1'b1;
                end
                S_TRAP: begin
                    illegal = illegal_q;
                    bus_err = bus_err_q;
                end
                default: ;
            endcase
        end
    end

    assign mem.mem_req = req;
    assign mem.mem_we  = we;
    assign state_dbg   = state;

endmodule
